// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix operand streaming datapath.
package matmul_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic ROLE_A = 1'b0;
    localparam logic ROLE_B = 1'b1;

    // Flat position of element (r,c) in a row-major n x n matrix.
    function automatic int elem_index(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/nested_index_counter.sv
// Three nested i/j/k counters (k innermost), each wrapping at N-1.
module nested_index_counter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic [IW-1:0] k,
    output logic          last_k,
    output logic          last_all
);

    // Wrap is explicit so a non-power-of-2 N never reaches 2^IW-1.
    localparam logic [IW-1:0] MAX_IDX = IW'(N - 1);

    logic last_j;
    logic last_i;

    assign last_k   = (k == MAX_IDX);
    assign last_j   = (j == MAX_IDX);
    assign last_i   = (i == MAX_IDX);
    assign last_all = last_k && last_j && last_i;

    // NOTE: sequential state uses non-blocking assignments so every counter
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (en) begin
            if (!last_k) begin
                k <= k + 1'b1;
            end else begin
                k <= '0;
                if (!last_j) begin
                    j <= j + 1'b1;
                end else begin
                    j <= '0;
                    i <= last_i ? '0 : i + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/matrix_operand_streamer.sv
// Captures an N x N matrix and streams it in i/j/k MAC order as A[i][k] or B[k][j].
module matrix_operand_streamer
    import matmul_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [N*N*W-1:0] matrix_in,
    input  logic             role,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     element,
    output logic             out_last_k,
    output logic             out_last
);

    localparam int IW = $clog2(N);

    state_t             state;
    logic [N*N*W-1:0]   matrix_q;
    logic               role_q;
    logic [IW-1:0]      cnt_i;
    logic [IW-1:0]      cnt_j;
    logic [IW-1:0]      cnt_k;
    logic               last_k;
    logic               last_all;
    logic               handshake;
    logic               load_fire;
    logic [IW-1:0]      row;
    logic [IW-1:0]      col;

    // Outputs are forced low during the reset cycle itself, not only after it.
    assign load_ready = (state == IDLE) && !rst;
    assign out_valid  = (state == STREAM) && !rst;
    assign handshake  = out_valid && out_ready;
    assign load_fire  = load_valid && load_ready;

    nested_index_counter #(.N(N), .IW(IW)) u_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (abort || load_fire || (handshake && last_all)),
        .en       (handshake && !abort),
        .i        (cnt_i),
        .j        (cnt_j),
        .k        (cnt_k),
        .last_k   (last_k),
        .last_all (last_all)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            // NOTE: the stored matrix is a plain register bank, so clearing it
            // on reset is cheap and keeps element deterministic.
            matrix_q <= '0;
            role_q   <= ROLE_A;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                STREAM: if (handshake && last_all) state <= IDLE;
                IDLE: begin
                    if (load_valid) begin
                        state    <= STREAM;
                        matrix_q <= matrix_in;
                        role_q   <= role;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A-role walks row i along k; B-role walks column j down k.
    assign row = (role_q == ROLE_B) ? cnt_k : cnt_i;
    assign col = (role_q == ROLE_B) ? cnt_j : cnt_k;

    always_comb begin
        element    = '0;
        out_last_k = 1'b0;
        out_last   = 1'b0;
        if (out_valid) begin
            element    = W'(matrix_q >> (elem_index(int'(row), int'(col), N) * W));
            out_last_k = last_k;
            out_last   = last_all;
        end
    end

endmodule

// File: tb/tb_matrix_operand_streamer.sv
// Scoreboard bench: expected operands are queued at load time and popped on each handshake.
module tb_matrix_operand_streamer;
    import matmul_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        abort2 = 1'b0, load_valid2 = 1'b0, role2 = 1'b0, out_ready2 = 1'b0;
    logic [15:0] matrix2 = '0;
    logic        load_ready2, out_valid2, out_last_k2, out_last2;
    logic [3:0]  element2;

    logic        abort3 = 1'b0, load_valid3 = 1'b0, role3 = 1'b0, out_ready3 = 1'b0;
    logic [71:0] matrix3 = '0;
    logic        load_ready3, out_valid3, out_last_k3, out_last3;
    logic [7:0]  element3;

    typedef struct packed {
        logic [7:0] el;
        logic       lk;
        logic       la;
    } exp_t;

    exp_t q2[$];
    exp_t q3[$];
    int   checks = 0;
    int   errors = 0;

    matrix_operand_streamer #(.N(2), .W(4)) dut2 (
        .clk(clk), .rst(rst), .abort(abort2), .load_valid(load_valid2),
        .load_ready(load_ready2), .matrix_in(matrix2), .role(role2),
        .out_valid(out_valid2), .out_ready(out_ready2), .element(element2),
        .out_last_k(out_last_k2), .out_last(out_last2)
    );

    matrix_operand_streamer #(.N(3), .W(8)) dut3 (
        .clk(clk), .rst(rst), .abort(abort3), .load_valid(load_valid3),
        .load_ready(load_ready3), .matrix_in(matrix3), .role(role3),
        .out_valid(out_valid3), .out_ready(out_ready3), .element(element3),
        .out_last_k(out_last_k3), .out_last(out_last3)
    );

    // Reference loop nest: which element a MAC datapath needs at step (i,j,k).
    function automatic exp_t model(input int n, input int w, input logic [71:0] m,
                                   input logic rl, input int i, input int j, input int k);
        int          r, c;
        logic [71:0] sh;
        exp_t        e;
        r    = rl ? k : i;
        c    = rl ? j : k;
        sh   = m >> ((r * n + c) * w);
        e.el = (w == 4) ? {4'b0, sh[3:0]} : sh[7:0];
        e.lk = (k == n - 1);
        e.la = (i == n - 1) && (j == n - 1) && (k == n - 1);
        return e;
    endfunction

    task automatic load2(input logic [15:0] m, input logic rl);
        @(negedge clk);
        load_valid2 = 1'b1;
        matrix2     = m;
        role2       = rl;
        #1;
        checks++;
        if (load_ready2 !== 1'b1)
            $display("FAIL load_ready2 before load: got %b want 1", load_ready2);
        q2.delete();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < 2; k++)
                    q2.push_back(model(2, 4, {56'b0, m}, rl, i, j, k));
        @(posedge clk);
        #1;
        load_valid2 = 1'b0;
        matrix2     = 16'hFFFF;
    endtask

    // Drains the dut2 stream; optional stall on element index stall_at and abort on abort_at.
    task automatic stream2(input int stall_at, input int stall_len, input int abort_at);
        int   hs = 0;
        int   stalls = 0;
        exp_t e;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            out_ready2 = !(hs == stall_at && stalls < stall_len);
            if (!out_ready2) stalls++;
            abort2 = (hs == abort_at);
            #1;
            checks++;
            if (out_valid2 !== 1'b1) begin
                errors++;
                $display("FAIL out_valid2 at element %0d: got %b want 1", hs, out_valid2);
                return;
            end
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL scoreboard2 underflow: got extra element %h want none", element2);
                return;
            end
            e = q2[0];
            checks++;
            if ({element2, out_last_k2, out_last2} !== {e.el[3:0], e.lk, e.la}) begin
                errors++;
                $display("FAIL element2 #%0d: got el=%h lk=%b la=%b want el=%h lk=%b la=%b",
                         hs, element2, out_last_k2, out_last2, e.el[3:0], e.lk, e.la);
            end
            if (abort2) begin
                @(posedge clk);
                #1;
                abort2 = 1'b0;
                @(negedge clk);
                #1;
                checks++;
                if ({load_ready2, out_valid2, element2, out_last_k2, out_last2} !== 8'b1000_0000) begin
                    errors++;
                    $display("FAIL abort2 idle: got %b want 10000000",
                             {load_ready2, out_valid2, element2, out_last_k2, out_last2});
                end
                q2.delete();
                return;
            end
            if (out_ready2) begin
                void'(q2.pop_front());
                hs++;
                if (e.la) begin
                    checks++;
                    if (load_ready2 !== 1'b0) begin
                        errors++;
                        $display("FAIL load_ready2 on final: got %b want 0", load_ready2);
                    end
                    load_valid2 = 1'b1;
                    @(posedge clk);
                    #1;
                    load_valid2 = 1'b0;
                    out_ready2  = 1'b0;
                    @(negedge clk);
                    #1;
                    checks++;
                    if ({load_ready2, out_valid2, element2, out_last_k2, out_last2} !== 8'b1000_0000) begin
                        errors++;
                        $display("FAIL bubble2 after final: got %b want 10000000",
                                 {load_ready2, out_valid2, element2, out_last_k2, out_last2});
                    end
                    return;
                end
            end
        end
        errors++;
        $display("FAIL stream2 timeout: got %0d elements want 8", hs);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({load_ready2, out_valid2, element2, out_last_k2, out_last2, load_ready3, out_valid3} !== 10'b0) begin
            errors++;
            $display("FAIL reset outputs: got %b want 0",
                     {load_ready2, out_valid2, element2, out_last_k2, out_last2, load_ready3, out_valid3});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({load_ready2, out_valid2, element2, out_last_k2, out_last2, load_ready3, out_valid3} !== 10'b10000000_10) begin
            errors++;
            $display("FAIL post-reset outputs: got %b want 1000000010",
                     {load_ready2, out_valid2, element2, out_last_k2, out_last2, load_ready3, out_valid3});
        end
    endtask

    task automatic test_role_b();
        load2(16'hDCBA, ROLE_B);
        stream2(-1, 0, -1);
    endtask

    task automatic test_role_a();
        load2(16'hDCBA, ROLE_A);
        stream2(-1, 0, -1);
    endtask

    task automatic test_backpressure();
        load2(16'hDCBA, ROLE_B);
        stream2(2, 3, -1);
    endtask

    task automatic test_abort();
        load2(16'hDCBA, ROLE_B);
        stream2(-1, 0, 4);
        load2(16'h4321, ROLE_B);
        stream2(-1, 0, -1);
    endtask

    task automatic test_rst_midstream();
        exp_t e;
        load2(16'hDCBA, ROLE_A);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            out_ready2 = 1'b1;
            #1;
            e = q2.pop_front();
            checks++;
            if ({out_valid2, element2} !== {1'b1, e.el[3:0]}) begin
                errors++;
                $display("FAIL pre-rst element #%0d: got v=%b el=%h want v=1 el=%h",
                         n, out_valid2, element2, e.el[3:0]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({load_ready2, out_valid2, element2, out_last_k2, out_last2} !== 8'b0) begin
            errors++;
            $display("FAIL rst mid-stream: got %b want 00000000",
                     {load_ready2, out_valid2, element2, out_last_k2, out_last2});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({load_ready2, out_valid2, element2, out_last_k2, out_last2} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL after rst: got %b want 10000000",
                     {load_ready2, out_valid2, element2, out_last_k2, out_last2});
        end
        q2.delete();

        load2(16'hDCBA, ROLE_B);
        @(negedge clk);
        rst         = 1'b1;
        abort2      = 1'b1;
        load_valid2 = 1'b1;
        matrix2     = 16'h1234;
        #1;
        checks++;
        if ({load_ready2, out_valid2, element2, out_last_k2, out_last2} !== 8'b0) begin
            errors++;
            $display("FAIL rst+abort+load: got %b want 00000000",
                     {load_ready2, out_valid2, element2, out_last_k2, out_last2});
        end
        @(negedge clk);
        rst         = 1'b0;
        abort2      = 1'b0;
        load_valid2 = 1'b0;
        #1;
        checks++;
        if ({load_ready2, out_valid2, element2, out_last_k2, out_last2} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL after rst+abort+load: got %b want 10000000",
                     {load_ready2, out_valid2, element2, out_last_k2, out_last2});
        end
        q2.delete();
        load2(16'h8765, ROLE_A);
        stream2(-1, 0, -1);
    endtask

    task automatic test_n3();
        exp_t e;
        int   got = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                matrix3[(r * 3 + c) * 8 +: 8] = 8'(r * 3 + c + 1);
        q3.delete();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                for (int k = 0; k < 3; k++)
                    q3.push_back(model(3, 8, matrix3, ROLE_B, i, j, k));
        @(negedge clk);
        load_valid3 = 1'b1;
        role3       = ROLE_B;
        @(posedge clk);
        #1;
        load_valid3 = 1'b0;
        for (int cyc = 0; cyc < 60 && q3.size() > 0; cyc++) begin
            @(negedge clk);
            out_ready3 = 1'b1;
            #1;
            e = q3.pop_front();
            got++;
            checks++;
            if ({out_valid3, element3, out_last_k3, out_last3} !== {1'b1, e.el, e.lk, e.la}) begin
                errors++;
                $display("FAIL n3 element #%0d: got v=%b el=%0d lk=%b la=%b want v=1 el=%0d lk=%b la=%b",
                         got, out_valid3, element3, out_last_k3, out_last3, e.el, e.lk, e.la);
            end
        end
        @(negedge clk);
        out_ready3 = 1'b0;
        #1;
        checks++;
        if ({got, load_ready3, out_valid3} !== {32'd27, 2'b10}) begin
            errors++;
            $display("FAIL n3 end: got count=%0d lr=%b v=%b want count=27 lr=1 v=0",
                     got, load_ready3, out_valid3);
        end
    endtask

    initial begin
        test_reset();
        test_role_b();
        test_role_a();
        test_backpressure();
        test_abort();
        test_rst_midstream();
        test_n3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_operand_streamer.md
Name: matrix_operand_streamer

Overview:
- Parametrised successor to the fixed 2x2 operand selector.
- Captures one N x N matrix of W-bit elements, then streams them in the order one multiply-accumulate datapath consumes them for C = A x B.
- Loop nest is i (outer), j, k (inner), giving N^3 elements per matrix.
- The role, chosen at load time, sets which element is emitted: A-role emits A[i][k]; B-role emits B[k][j]. Two instances (one per role) feed the multiplier in lockstep through valid/ready.

Parameters:
- N, 2, matrix dimension (N >= 2).
- W, 4, element width in bits.
- IW, $clog2(N), index counter width (derived, not overridden).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- abort  input  1  synchronous cancel of the current stream.
- load_valid  input  1  matrix_in and role are valid.
- load_ready  output  1  block can accept a load.
- matrix_in  input  N*N*W  flat matrix; element (r,c) is at bits [(r*N+c)*W +: W].
- role  input  1  0 = A-role (emit [i][k]), 1 = B-role (emit [k][j]); sampled on load.
- out_valid  output  1  element is valid.
- out_ready  input  1  consumer accepts the element.
- element  output  W  current operand.
- out_last_k  output  1  current element has k == N-1 (last term of a dot product).
- out_last  output  1  final element of the stream (i = j = k = N-1).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- States:
  - IDLE: load_ready = 1, out_valid = 0.
  - STREAM: load_ready = 0, out_valid = 1.
- Reset (rst = 1 at a clk edge):
  - State goes to IDLE; i, j, k, stored matrix and stored role are cleared to 0.
  - During the reset cycle, load_ready = 0 and out_valid = 0. After reset, load_ready = 1.
  - element, out_last_k and out_last are 0 whenever state is IDLE.
- Load: load_valid && load_ready at an edge captures matrix_in and role, clears i, j, k, and enters STREAM.
  - out_valid is asserted the following cycle, so load-to-first-element latency is 1 cycle.
- element is a combinational mux of the stored matrix indexed by the registered counters.
  - It is stable for as long as out_valid && !out_ready holds. Valid never drops without a handshake, except on abort or rst.
- Advance occurs only on out_valid && out_ready:
  - k increments.
  - When k == N-1, k wraps to 0 and j increments.
  - When j also == N-1, j wraps to 0 and i increments.
- Handshake on out_last: returns to IDLE; load_ready = 1 on the next cycle.
  - A load is never accepted in the same cycle as the final handshake, so there is one bubble cycle between streams.
- abort = 1 at an edge: state goes to IDLE and counters clear. Any handshake in that cycle is discarded. The stored matrix is retained but unused.
- Priority: rst > abort > final handshake > advance > load.
- Loads while in STREAM are not possible (load_ready = 0), and matrix_in is ignored.
- Counters are IW bits wide and never exceed N-1; non-power-of-2 N wraps at N-1, not at 2^IW.

Decomposition:
- Package matmul_pkg holds:
  - state typedef (IDLE, STREAM);
  - role constants ROLE_A = 0, ROLE_B = 1;
  - a function elem_index(r, c, N) returning r*N+c.
- One natural sub-module, nested_index_counter: three IW-bit counters with an enable, synchronous clear, per-level wrap at N-1, and outputs i, j, k, last_k, last_all.

Test Plan:
- N=2, W=4, role=B, matrix_in=16'hDCBA, out_ready held 1:
  - Emits A,C,B,D,A,C,B,D on consecutive cycles.
  - out_last_k high on the 2nd/4th/6th/8th elements; out_last only on the 8th.
  - load_ready returns to 1 one cycle after the final handshake.
- Same matrix, role=A: emits A,B,A,B,C,D,C,D.
- Backpressure: out_ready = 0 for 3 cycles on the 3rd element. element stays at B (B-role) and out_valid stays 1 throughout; the sequence then resumes with D.
- abort asserted on the 5th element with out_ready = 1: out_valid = 0 and load_ready = 1 the next cycle. A new load restarts from element (0,0).
- rst asserted mid-stream, and again concurrently with abort and a load: IDLE next cycle, all outputs 0, load_ready = 0 during reset, load_ready = 1 after.
- N=3, W=8, role=B, elements 1..9: 27 elements, beginning 1,4,7,2,5,8,3,6,9. out_last_k fires every 3rd element; out_last only on the 27th.
